// File: rtl/vga_scan_timing.sv
// VGA raster timing generator: counters, stage-0 X/Y/blank registers, and a
// two-stage pipeline that aligns sync/blank to colour returned by the averager.
module vga_scan_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  output logic [9:0] oVGA_X,
  output logic [9:0] oVGA_Y,
  output logic       oVGA_BLANK,
  output logic       oFRAME_START,
  input  logic [4:0] iRed,
  input  logic [4:0] iGreen,
  input  logic [4:0] iBlue,
  output logic [9:0] oVGA_R,
  output logic [9:0] oVGA_G,
  output logic [9:0] oVGA_B,
  output logic       oVGA_HS,
  output logic       oVGA_VS,
  output logic       oVGA_BLANK_N,
  output logic       oVGA_SYNC_N
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT        = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT        = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef struct packed {
    logic blank;
    logic hs;
    logic vs;
  } vid_ctl_t;

  // Syncs idle high and video is blanked whenever the pipeline is cleared.
  localparam vid_ctl_t CTL_IDLE = '{blank: 1'b0, hs: 1'b1, vs: 1'b1};

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_act, v_act;
  vid_ctl_t      ctl_raw, ctl_0, ctl_1, ctl_2;
  logic [4:0]    red_q, green_q, blue_q;

  // NOTE: every clocked register uses non-blocking assignment so all stages
  // sample pre-edge values and the pipeline shifts by exactly one per clock.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign h_act      = (h_cnt < H_ACT);
  assign v_act      = (v_cnt < V_ACT);
  assign ctl_raw.blank = h_act && v_act;
  assign ctl_raw.hs = !((h_cnt >= H_SYNC_FIRST) && (h_cnt <= H_SYNC_LAST));
  assign ctl_raw.vs = !((v_cnt >= V_SYNC_FIRST) && (v_cnt <= V_SYNC_LAST));

  // Stage 0: registered view of the counters; this is the X/Y the averager sees.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oVGA_X       <= '0;
      oVGA_Y       <= '0;
      oFRAME_START <= 1'b0;
      ctl_0        <= CTL_IDLE;
    end else begin
      oVGA_X       <= h_act ? 10'(h_cnt) : '0;
      oVGA_Y       <= v_act ? 10'(v_cnt) : '0;
      oFRAME_START <= (h_cnt == '0) && (v_cnt == '0);
      ctl_0        <= ctl_raw;
    end
  end

  assign oVGA_BLANK = ctl_0.blank;

  // Colour for pixel N arrives one clock after X/Y = N, so capturing it here
  // lines it up with the control bits that have travelled two stages.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      ctl_1   <= CTL_IDLE;
      ctl_2   <= CTL_IDLE;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      ctl_1   <= ctl_0;
      ctl_2   <= ctl_1;
      red_q   <= iRed;
      green_q <= iGreen;
      blue_q  <= iBlue;
    end
  end

  assign oVGA_R       = ctl_2.blank ? {red_q, red_q}     : '0;
  assign oVGA_G       = ctl_2.blank ? {green_q, green_q} : '0;
  assign oVGA_B       = ctl_2.blank ? {blue_q, blue_q}   : '0;
  assign oVGA_HS      = ctl_2.hs;
  assign oVGA_VS      = ctl_2.vs;
  assign oVGA_BLANK_N = ctl_2.blank;
  assign oVGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Directed bench: a default-timing instance for full-width line checks and a
// shrunken-timing instance (32 x 19 clocks per frame) for whole-frame checks.
module tb_vga_scan_timing;

  localparam int S_FRAME = 608;
  localparam logic [55:0] RST_VEC = {20'd0, 2'b00, 30'd0, 4'b1100};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] red, green, blue, red_const, avg_q;
  logic       avg_mode = 1'b0;
  int         checks = 0;
  int         errors = 0;

  logic [9:0] d_x, d_y, d_r, d_g, d_b;
  logic       d_blank, d_fs, d_hs, d_vs, d_blank_n, d_sync_n;
  logic [9:0] s_x, s_y, s_r, s_g, s_b;
  logic       s_blank, s_fs, s_hs, s_vs, s_blank_n, s_sync_n;

  always #5 clk = ~clk;

  // Averager model: returns the low bits of X one clock later.
  always @(posedge clk) avg_q <= s_x[4:0];
  assign red = avg_mode ? avg_q : red_const;

  vga_scan_timing u_dflt (
    .iCLK(clk), .iRST_N(rst_n),
    .oVGA_X(d_x), .oVGA_Y(d_y), .oVGA_BLANK(d_blank), .oFRAME_START(d_fs),
    .iRed(red), .iGreen(green), .iBlue(blue),
    .oVGA_R(d_r), .oVGA_G(d_g), .oVGA_B(d_b),
    .oVGA_HS(d_hs), .oVGA_VS(d_vs), .oVGA_BLANK_N(d_blank_n), .oVGA_SYNC_N(d_sync_n)
  );

  vga_scan_timing #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_small (
    .iCLK(clk), .iRST_N(rst_n),
    .oVGA_X(s_x), .oVGA_Y(s_y), .oVGA_BLANK(s_blank), .oFRAME_START(s_fs),
    .iRed(red), .iGreen(green), .iBlue(blue),
    .oVGA_R(s_r), .oVGA_G(s_g), .oVGA_B(s_b),
    .oVGA_HS(s_hs), .oVGA_VS(s_vs), .oVGA_BLANK_N(s_blank_n), .oVGA_SYNC_N(s_sync_n)
  );

  // Returns at a falling edge with reset just released; the next falling
  // edge observes stage-0 at (0,0).
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [55:0] got;
    red_const = 5'd31; green = 5'd31; blue = 5'd31;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    got = {s_x, s_y, s_blank, s_fs, s_r, s_g, s_b, s_hs, s_vs, s_blank_n, s_sync_n};
    checks++;
    if (got !== RST_VEC) begin
      errors++; $display("FAIL reset_small: got %h expected %h", got, RST_VEC);
    end
    got = {d_x, d_y, d_blank, d_fs, d_r, d_g, d_b, d_hs, d_vs, d_blank_n, d_sync_n};
    checks++;
    if (got !== RST_VEC) begin
      errors++; $display("FAIL reset_default: got %h expected %h", got, RST_VEC);
    end
  endtask

  task automatic test_first_edge();
    do_reset();
    @(negedge clk);
    checks++;
    if ({s_fs, s_blank, s_x, s_y} !== {1'b1, 1'b1, 20'd0}) begin
      errors++; $display("FAIL first_edge_small: fs=%b blank=%b x=%0d y=%0d expected 1 1 0 0",
                         s_fs, s_blank, s_x, s_y);
    end
    checks++;
    if ({d_fs, d_blank, d_x} !== {1'b1, 1'b1, 10'd0}) begin
      errors++; $display("FAIL first_edge_default: fs=%b blank=%b x=%0d expected 1 1 0",
                         d_fs, d_blank, d_x);
    end
    @(negedge clk);
    checks++;
    if ({s_fs, s_x, d_fs, d_x} !== {1'b0, 10'd1, 1'b0, 10'd1}) begin
      errors++; $display("FAIL second_edge: s_fs=%b s_x=%0d d_fs=%b d_x=%0d expected 0 1 0 1",
                         s_fs, s_x, d_fs, d_x);
    end
  endtask

  task automatic test_frame_timing();
    int fs_pos[4];
    int fs_n = 0, hs_run = 0, hs_falls = 0, vs_low = 0, vs_falls = 0, vs_first = -1;
    int bn_high = 0;
    logic vs_prev = 1'b1;
    do_reset();
    @(negedge clk);
    for (int i = 1; i <= 2 * S_FRAME; i++) begin
      @(negedge clk);
      if (s_fs && fs_n < 4) begin fs_pos[fs_n] = i; fs_n++; end
      if (!s_hs) hs_run++;
      else if (hs_run != 0) begin
        hs_falls++;
        checks++;
        if (hs_run != 8) begin
          errors++; $display("FAIL hs_width: got %0d expected 8 at i=%0d", hs_run, i);
        end
        hs_run = 0;
      end
      if (!s_vs) begin
        vs_low++;
        if (vs_first < 0) vs_first = i;
        if (vs_prev) vs_falls++;
      end
      vs_prev = s_vs;
      if (s_blank_n) bn_high++;
    end
    checks++;
    if (fs_n != 2 || fs_pos[0] != S_FRAME || fs_pos[1] != 2 * S_FRAME) begin
      errors++; $display("FAIL frame_period: pulses=%0d first=%0d second=%0d expected 2 608 1216",
                         fs_n, fs_pos[0], fs_pos[1]);
    end
    checks++;
    if (hs_falls != 38) begin
      errors++; $display("FAIL hs_count: got %0d expected 38", hs_falls);
    end
    checks++;
    if (vs_low != 128 || vs_falls != 2) begin
      errors++; $display("FAIL vs_low: got %0d clocks in %0d pulses expected 128 in 2",
                         vs_low, vs_falls);
    end
    checks++;
    if (vs_first != 450) begin
      errors++; $display("FAIL vs_start: got %0d expected 450", vs_first);
    end
    checks++;
    if (bn_high != 384) begin
      errors++; $display("FAIL blank_n_count: got %0d expected 384", bn_high);
    end
  endtask

  task automatic test_default_line();
    int hs_low = 0, hs_first = -1, bn_rise = -1, bn_fall = -1;
    logic [9:0] exp_x;
    logic       exp_b;
    do_reset();
    for (int i = 0; i <= 801; i++) begin
      @(negedge clk);
      if (i < 800) begin
        exp_x = (i < 640) ? 10'(i) : 10'd0;
        exp_b = (i < 640);
        checks++;
        if ({d_x, d_blank, d_y} !== {exp_x, exp_b, 10'd0}) begin
          errors++; $display("FAIL line_pixel %0d: x=%0d blank=%b y=%0d expected %0d %b 0",
                             i, d_x, d_blank, d_y, exp_x, exp_b);
        end
      end
      if (!d_hs) begin hs_low++; if (hs_first < 0) hs_first = i; end
      if (d_blank_n && bn_rise < 0) bn_rise = i;
      if (!d_blank_n && bn_rise >= 0 && bn_fall < 0) bn_fall = i;
    end
    checks++;
    if (hs_first != 658 || hs_low != 96) begin
      errors++; $display("FAIL default_hs: first=%0d width=%0d expected 658 96", hs_first, hs_low);
    end
    checks++;
    if (bn_rise != 2 || bn_fall != 642) begin
      errors++; $display("FAIL default_blank_n: rise=%0d fall=%0d expected 2 642", bn_rise, bn_fall);
    end
  endtask

  task automatic test_colour();
    int active = 0;
    logic [29:0] exp_rgb;
    red_const = 5'd31; green = 5'd0; blue = 5'd16;
    do_reset();
    for (int i = 0; i < S_FRAME; i++) begin
      @(negedge clk);
      exp_rgb = s_blank_n ? {10'h3FF, 10'h000, 10'h210} : 30'd0;
      if (s_blank_n) active++;
      checks++;
      if ({s_r, s_g, s_b} !== exp_rgb) begin
        errors++; $display("FAIL colour %0d: got %h expected %h", i, {s_r, s_g, s_b}, exp_rgb);
      end
    end
    checks++;
    if (active != 192) begin
      errors++; $display("FAIL colour_active: got %0d expected 192", active);
    end
  endtask

  task automatic test_averager();
    logic [4:0] h5;
    logic [9:0] exp_r;
    avg_mode = 1'b1;
    green = 5'd0; blue = 5'd0;
    do_reset();
    for (int i = 0; i <= 33; i++) begin
      @(negedge clk);
      if (i == 1 || i == 2) begin
        checks++;
        if ({s_blank, s_blank_n} !== {1'b1, (i == 2)}) begin
          errors++; $display("FAIL avg_blank_align i=%0d: blank=%b blank_n=%b expected 1 %b",
                             i, s_blank, s_blank_n, (i == 2));
        end
      end
      if (i >= 2) begin
        h5 = 5'(i - 2);
        exp_r = (i - 2 < 16) ? {h5, h5} : 10'd0;
        checks++;
        if (s_r !== exp_r) begin
          errors++; $display("FAIL avg_red h=%0d: got %h expected %h", i - 2, s_r, exp_r);
        end
      end
    end
    avg_mode = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [55:0] got;
    int vs_first = -1, hs_first = -1;
    red_const = 5'd31; green = 5'd31; blue = 5'd31;
    do_reset();
    @(negedge clk);
    repeat (6 * 32 + 24) @(negedge clk);
    checks++;
    if (s_hs !== 1'b0) begin
      errors++; $display("FAIL mid_pre_hs: got %b expected 0", s_hs);
    end
    rst_n = 1'b0;
    #1;
    got = {s_x, s_y, s_blank, s_fs, s_r, s_g, s_b, s_hs, s_vs, s_blank_n, s_sync_n};
    checks++;
    if (got !== RST_VEC) begin
      errors++; $display("FAIL mid_reset_small: got %h expected %h", got, RST_VEC);
    end
    got = {d_x, d_y, d_blank, d_fs, d_r, d_g, d_b, d_hs, d_vs, d_blank_n, d_sync_n};
    checks++;
    if (got !== RST_VEC) begin
      errors++; $display("FAIL mid_reset_default: got %h expected %h", got, RST_VEC);
    end
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_fs, s_hs, s_vs} !== 3'b111) begin
      errors++; $display("FAIL mid_restart: fs=%b hs=%b vs=%b expected 1 1 1", s_fs, s_hs, s_vs);
    end
    for (int i = 1; i <= 460; i++) begin
      @(negedge clk);
      if (!s_vs && vs_first < 0) vs_first = i;
      if (!s_hs && hs_first < 0) hs_first = i;
    end
    checks++;
    if (vs_first != 450 || hs_first != 22) begin
      errors++; $display("FAIL mid_first_sync: vs=%0d hs=%0d expected 450 22", vs_first, hs_first);
    end
  endtask

  initial begin
    red_const = 5'd0; green = 5'd0; blue = 5'd0;
    test_reset();
    test_first_edge();
    test_frame_timing();
    test_default_line();
    test_colour();
    test_averager();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_scan_timing.md
VGA_SCAN_TIMING -- requirements
Module: vga_scan_timing

Interface
REQ-001 The block SHALL be parameterised as follows, one parameter per line (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in clocks
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch

REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; ports are listed one per line (name, direction, width, meaning):
- iCLK, in, 1, pixel clock (25.175 MHz nominal)
- iRST_N, in, 1, asynchronous reset, active low
- oVGA_X, out, 10, pixel column requested from the averager stage
- oVGA_Y, out, 10, pixel row requested from the averager stage
- oVGA_BLANK, out, 1, 1 = active video at the current X/Y
- oFRAME_START, out, 1, one-clock pulse on the first active pixel (0,0)
- iRed, iGreen, iBlue, in, 5 each, colour returned by the averager, registered one clock after X/Y
- oVGA_R, oVGA_G, oVGA_B, out, 10 each, DAC colour
- oVGA_HS, oVGA_VS, out, 1, sync outputs, active low
- oVGA_BLANK_N, out, 1, DAC blank, active low
- oVGA_SYNC_N, out, 1, DAC composite sync, tied to 0

Function
REQ-003 h_cnt SHALL count 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800, and wrap to 0.
REQ-004 v_cnt SHALL increment only when h_cnt wraps, count 0..V_TOTAL-1 (V_TOTAL = 525), and wrap to 0 when h_cnt and v_cnt both wrap in the same clock.
REQ-005 The region ordering SHALL be active, front porch, sync, back porch; h_cnt 0..639 and v_cnt 0..479 are active.
REQ-006 Stage-0 outputs (oVGA_X, oVGA_Y, oVGA_BLANK, oFRAME_START) SHALL be registered outputs of the counters.
REQ-007 oVGA_BLANK SHALL be 1 iff h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-008 oVGA_X SHALL equal h_cnt when h_cnt < H_ACTIVE and 0 otherwise; oVGA_Y SHALL equal v_cnt when v_cnt < V_ACTIVE and 0 otherwise.
REQ-009 Raw hsync SHALL be low for h_cnt in [656, 751]; raw vsync SHALL be low for v_cnt in [490, 491].
REQ-010 oFRAME_START SHALL be 1 for exactly one clock per frame, in the clock where h_cnt = 0 and v_cnt = 0.
REQ-011 Because the averager returns colour one clock after X/Y, the block SHALL delay raw hsync, vsync and BLANK through a 2-stage pipeline so that the DAC outputs are aligned to the colour.
REQ-012 The block SHALL register iRed/iGreen/iBlue once (the pipeline's second stage); the DAC colour SHALL be the 5-bit value replicated to 10 bits ({c,c}), giving a maximum of 0x3FF for c = 31.
REQ-013 The DAC colour SHALL be forced to 0 whenever the delayed BLANK is 0, regardless of the iRed/iGreen/iBlue inputs.
REQ-014 oVGA_BLANK_N SHALL equal the 2-cycle-delayed BLANK; oVGA_HS and oVGA_VS SHALL equal the 2-cycle-delayed raw syncs.
REQ-015 Total latency from the counter value to the DAC pins SHALL be 2 clocks for sync, blank and colour.
REQ-016 Parameter values SHALL be synthesis-time constants only; there SHALL be no run-time mode changes.

Reset
REQ-017 Asserting iRST_N low at any time SHALL immediately clear h_cnt, v_cnt and all pipeline registers, with no clock required.
REQ-018 While iRST_N is low, outputs SHALL hold at the following values:
- oVGA_X = 0, oVGA_Y = 0
- oVGA_BLANK = 0, oFRAME_START = 0
- oVGA_R/G/B = 0
- oVGA_HS = 1, oVGA_VS = 1, oVGA_BLANK_N = 0, oVGA_SYNC_N = 0
REQ-019 On the first rising edge after release, counting SHALL start at h_cnt = 0, v_cnt = 0; oFRAME_START SHALL pulse in that first clock.
REQ-020 Reset asserted mid-frame SHALL abandon the frame; the next frame SHALL begin cleanly at (0,0) with no partial sync pulse.

Verification
REQ-021 Release reset and run 2 frames: exactly 420000 clocks between consecutive oFRAME_START pulses; 525 oVGA_HS low pulses per frame, each 96 clocks wide.
REQ-022 Sample the line containing v_cnt = 100: oVGA_BLANK = 1 for exactly 640 consecutive clocks with oVGA_X = 0..639 in order, then oVGA_X = 0 and oVGA_BLANK = 0 for 160 clocks.
REQ-023 Drive iRed = 31, iGreen = 0, iBlue = 16 constantly: during active DAC cycles oVGA_R = 0x3FF, oVGA_G = 0, oVGA_B = 0x210; during blank all three are 0.
REQ-024 Drive iRed equal to the low 5 bits of oVGA_X delayed one clock (an averager model): oVGA_R at the first active DAC pixel = 0, and the rising edge of oVGA_BLANK_N is exactly 2 clocks after the rising edge of oVGA_BLANK.
REQ-025 Vertical sync: oVGA_VS low for exactly 2 × 800 = 1600 clocks per frame, starting 2 clocks after h_cnt = 0, v_cnt = 490.
REQ-026 Pulse iRST_N low for 3 ns at (h_cnt = 300, v_cnt = 200), between clock edges: outputs go to their reset values immediately; after release, oFRAME_START asserts on the first edge and no oVGA_VS pulse occurs before v_cnt = 490.
